get_seq_fsm: RTL and testbench

- Parametrised GET-operation sequencer for the cache controller.
- On `enter` it latches a key and issues a lookup request to the key store. On hit it reads a multi-word value from the value memory and streams it out. On miss it reports the miss.
- Instantiated by the top-level controller FSM, which drives `en`/`enter` exactly as for the other per-command sub-FSMs.

---
 rtl/ctrl_types_pkg.sv | 32 +++
 rtl/get_seq_fsm.sv | 192 +++++++++++++++++++
 tb/tb_get_seq_fsm.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_types_pkg.sv
// ============================================================================
//  Module   : ctrl_types_pkg
//  Purpose  : Shared cache-controller types: GET sequencer states and result.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ctrl_types_pkg;

    typedef enum logic [2:0] {
        GET_ST_START  = 3'd0,
        GET_ST_LOOKUP = 3'd1,
        GET_ST_WAIT   = 3'd2,
        GET_ST_READ   = 3'd3,
        GET_ST_RDATA  = 3'd4,
        GET_ST_STREAM = 3'd5,
        GET_ST_DONE   = 3'd6
    } get_state_e;

    typedef struct packed {
        logic hit;
        logic err;
    } get_result_t;

    // Counter/index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/get_seq_fsm.sv
// ============================================================================
//  Module   : get_seq_fsm
//  Purpose  : GET sequencer: key lookup, multi-word value read and streaming.
//             GET_SEQ_TIMEOUT_EN adds a lookup-response timeout.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module get_seq_fsm
    import ctrl_types_pkg::*;
#(
    parameter  int KEY_W       = 32,
    parameter  int VAL_W       = 32,
    parameter  int NUM_ENTRIES = 16,
    parameter  int VALUE_WORDS = 4,
    parameter  int TIMEOUT_CYC = 64,
    localparam int IDX_W       = clog2_min1(NUM_ENTRIES),
    localparam int WCNT_W      = clog2_min1(VALUE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              enter,
    input  logic [KEY_W-1:0]  key_i,
    output logic              lk_req_valid_o,
    output logic [KEY_W-1:0]  lk_key_o,
    input  logic              lk_req_ready_i,
    input  logic              lk_resp_valid_i,
    input  logic              lk_hit_i,
    input  logic [IDX_W-1:0]  lk_idx_i,
    output logic              rd_en_o,
    output logic [IDX_W-1:0]  rd_idx_o,
    output logic [WCNT_W-1:0] rd_word_o,
    input  logic [VAL_W-1:0]  rd_data_i,
    output logic              val_valid_o,
    output logic [VAL_W-1:0]  val_data_o,
    output logic              val_last_o,
    input  logic              val_ready_i,
    output logic              done_o,
    output logic              hit_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam logic [WCNT_W-1:0] c_last_word = WCNT_W'(VALUE_WORDS - 1);

`ifdef GET_SEQ_TIMEOUT_EN
    localparam int                TCNT_W      = clog2_min1(TIMEOUT_CYC);
    localparam logic [TCNT_W-1:0] c_tcnt_last = TCNT_W'(TIMEOUT_CYC - 1);
    logic [TCNT_W-1:0] r_tcnt;
`endif

    get_state_e        r_state;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_lk_req_valid;
    logic [KEY_W-1:0]  r_lk_key;
    logic              r_rd_en;
    logic [IDX_W-1:0]  r_rd_idx;
    logic              r_val_valid;
    logic [VAL_W-1:0]  r_val_data;
    logic              r_val_last;
    logic              r_done;
    get_result_t       r_res;
    logic              r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= GET_ST_START;
            r_wcnt         <= '0;
            r_lk_req_valid <= 1'b0;
            r_lk_key       <= '0;
            r_rd_en        <= 1'b0;
            r_rd_idx       <= '0;
            r_val_valid    <= 1'b0;
            r_val_data     <= '0;
            r_val_last     <= 1'b0;
            r_done         <= 1'b0;
            r_res          <= '0;
            r_busy         <= 1'b0;
`ifdef GET_SEQ_TIMEOUT_EN
            r_tcnt         <= '0;
`endif
        end else if (enter) begin
            // Restart abandons whatever was in flight, independent of en.
            r_state        <= GET_ST_LOOKUP;
            r_lk_key       <= key_i;
            r_wcnt         <= '0;
            r_lk_req_valid <= 1'b1;
            r_rd_en        <= 1'b0;
            r_val_valid    <= 1'b0;
            r_val_last     <= 1'b0;
            r_done         <= 1'b0;
            r_res          <= '0;
            r_busy         <= 1'b1;
`ifdef GET_SEQ_TIMEOUT_EN
            r_tcnt         <= '0;
`endif
        end else if (en) begin
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= '0;
            case (r_state)
                GET_ST_START: r_busy <= 1'b0;
                GET_ST_LOOKUP: begin
                    if (lk_req_ready_i) begin
                        r_lk_req_valid <= 1'b0;
                        r_state        <= GET_ST_WAIT;
`ifdef GET_SEQ_TIMEOUT_EN
                        r_tcnt         <= '0;
`endif
                    end
                end
                GET_ST_WAIT: begin
                    if (lk_resp_valid_i) begin
                        if (lk_hit_i) begin
                            r_rd_idx <= lk_idx_i;
                            r_rd_en  <= 1'b1;
                            r_state  <= GET_ST_READ;
                        end else begin
                            r_done   <= 1'b1;
                            r_state  <= GET_ST_DONE;
                        end
                    end
`ifdef GET_SEQ_TIMEOUT_EN
                    else if (r_tcnt == c_tcnt_last) begin
                        r_res.err <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= GET_ST_DONE;
                    end else begin
                        r_tcnt    <= r_tcnt + TCNT_W'(1);
                    end
`endif
                end
                GET_ST_READ: r_state <= GET_ST_RDATA;
                GET_ST_RDATA: begin
                    // Memory data is valid only in the cycle after the strobe.
                    r_val_data  <= rd_data_i;
                    r_val_valid <= 1'b1;
                    r_val_last  <= (r_wcnt == c_last_word);
                    r_state     <= GET_ST_STREAM;
                end
                GET_ST_STREAM: begin
                    if (val_ready_i) begin
                        r_val_valid <= 1'b0;
                        r_val_last  <= 1'b0;
                        if (r_val_last) begin
                            r_done    <= 1'b1;
                            r_res.hit <= 1'b1;
                            r_state   <= GET_ST_DONE;
                        end else begin
                            r_wcnt    <= r_wcnt + WCNT_W'(1);
                            r_rd_en   <= 1'b1;
                            r_state   <= GET_ST_READ;
                        end
                    end
                end
                GET_ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= GET_ST_START;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= GET_ST_START;
                end
            endcase
        end
    end

    assign lk_req_valid_o = r_lk_req_valid;
    assign lk_key_o       = r_lk_key;
    assign rd_en_o        = r_rd_en;
    assign rd_idx_o       = r_rd_idx;
    assign rd_word_o      = r_wcnt;
    assign val_valid_o    = r_val_valid;
    assign val_data_o     = r_val_data;
    assign val_last_o     = r_val_last;
    // A restart in the completion cycle suppresses the pulse.
    assign done_o         = r_done & ~enter;
    assign hit_o          = r_res.hit;
    assign busy_o         = r_busy;

`ifdef GET_SEQ_TIMEOUT_EN
    assign err_o = r_res.err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = r_res.err ^ (TIMEOUT_CYC != 0);
    assign err_o        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_get_seq_fsm.sv
// ============================================================================
//  Module   : tb_get_seq_fsm
//  Purpose  : Randomized self-checking bench for get_seq_fsm against an
//             event-level model of the GET transaction.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_get_seq_fsm;

    localparam int KW = 32;
    localparam int VWD = 32;
    localparam int NE = 16;
    localparam int VW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, en, enter;
    logic [KW-1:0]  key_i, lk_key_o;
    logic           lk_req_valid_o, lk_req_ready_i, lk_resp_valid_i, lk_hit_i;
    logic [3:0]     lk_idx_i, rd_idx_o;
    logic           rd_en_o;
    logic [1:0]     rd_word_o;
    logic [VWD-1:0] rd_data_i, val_data_o;
    logic           val_valid_o, val_last_o, val_ready_i;
    logic           done_o, hit_o, err_o, busy_o;

    get_seq_fsm #(
        .KEY_W(KW), .VAL_W(VWD), .NUM_ENTRIES(NE), .VALUE_WORDS(VW), .TIMEOUT_CYC(TO)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .enter(enter), .key_i(key_i),
        .lk_req_valid_o(lk_req_valid_o), .lk_key_o(lk_key_o),
        .lk_req_ready_i(lk_req_ready_i), .lk_resp_valid_i(lk_resp_valid_i),
        .lk_hit_i(lk_hit_i), .lk_idx_i(lk_idx_i),
        .rd_en_o(rd_en_o), .rd_idx_o(rd_idx_o), .rd_word_o(rd_word_o),
        .rd_data_i(rd_data_i),
        .val_valid_o(val_valid_o), .val_data_o(val_data_o), .val_last_o(val_last_o),
        .val_ready_i(val_ready_i),
        .done_o(done_o), .hit_o(hit_o), .err_o(err_o), .busy_o(busy_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    logic [VWD-1:0] mem [NE][VW];

    // Transaction model: what the GET should be doing, expressed as events.
    bit          m_active, m_req, m_wait, m_val, m_done, m_hit, m_err;
    logic [31:0] m_key;
    logic [3:0]  m_idx;
    int          m_rd_due, m_val_from, m_resp_at, m_beat, m_wait_cnt;

    // Environment knobs.
    int          en_pct = 100, rdy_pct = 100, ks_lat = 2, abort_pm = 0;
    int          bp_beat = -1, bp_left = 0;
    bit          ks_hit, ks_spur, tput_on, pulse_in_wait;
    logic [3:0]  ks_idx;

    bit          prev_rd;
    logic [3:0]  prev_rd_idx;
    logic [1:0]  prev_rd_word;
    int          n_rd, n_beat, last_acc;
    bit          seen_done, seen_hit, seen_err;

    task automatic model_clear();
        m_active = 0; m_req = 0; m_wait = 0; m_val = 0; m_done = 0;
        m_rd_due = -1; m_val_from = -1; m_resp_at = -1; m_beat = 0; m_wait_cnt = 0;
        prev_rd = 0;
    endtask

    task automatic step(input bit do_enter, input logic [31:0] nkey);
        bit force_en;
        enter    = do_enter;
        key_i    = do_enter ? nkey : $urandom;
        // Memory and key-store contracts need en in the strobe/data/response cycles.
        force_en = (cyc == m_rd_due) || (cyc == m_rd_due + 1) || (m_wait && cyc == m_resp_at);
        en          = force_en || ($urandom_range(99) < en_pct);
        val_ready_i = ($urandom_range(99) < rdy_pct);
        if (m_val && m_beat == bp_beat && bp_left > 0) begin
            val_ready_i = 1'b0;
            if (bp_left <= 3) en = 1'b0;
            bp_left--;
        end
        lk_req_ready_i  = 1'($urandom_range(1));
        lk_resp_valid_i = (cyc == m_resp_at);
        lk_hit_i        = lk_resp_valid_i ? ks_hit : 1'($urandom_range(1));
        lk_idx_i        = lk_resp_valid_i ? ks_idx : 4'($urandom);
        if (ks_spur && m_req && lk_req_ready_i) begin
            lk_resp_valid_i = 1'b1;
            lk_hit_i        = 1'b1;
            lk_idx_i        = 4'($urandom);
        end
        rd_data_i = prev_rd ? mem[prev_rd_idx][prev_rd_word] : $urandom;
        #1;
        check_eq("busy", busy_o, m_active);
        check_eq("lk_req_valid", lk_req_valid_o, m_req);
        if (m_req) check_eq("lk_key", lk_key_o, m_key);
        check_eq("rd_en", rd_en_o, cyc == m_rd_due);
        if (rd_en_o) begin
            check_eq("rd_idx", rd_idx_o, m_idx);
            check_eq("rd_word", rd_word_o, m_beat);
            n_rd++;
        end
        check_eq("val_valid", val_valid_o, m_val);
        if (m_val) begin
            check_eq("val_data", val_data_o, mem[m_idx][m_beat]);
            check_eq("val_last", val_last_o, m_beat == VW - 1);
        end
        check_eq("done", done_o, m_done && !enter);
        if (done_o) begin
            check_eq("hit", hit_o, m_hit);
            check_eq("err", err_o, m_err);
            seen_done = 1; seen_hit = hit_o; seen_err = err_o;
        end
        prev_rd = rd_en_o; prev_rd_idx = rd_idx_o; prev_rd_word = rd_word_o;
        if (pulse_in_wait && m_wait) begin
            rst_n = 1'b0; #2; rst_n = 1'b1;
            pulse_in_wait = 0;
        end
        @(posedge clk); #1;
        if (enter) begin
            m_active = 1; m_req = 1; m_key = key_i; m_wait = 0; m_val = 0; m_done = 0;
            m_rd_due = -1; m_val_from = -1; m_resp_at = -1; m_beat = 0; m_wait_cnt = 0;
            n_rd = 0; n_beat = 0; last_acc = -1; seen_done = 0;
        end else if (en) begin
            if (m_done) begin m_done = 0; m_active = 0; end
            if (m_wait) begin
                if (lk_resp_valid_i) begin
                    m_wait = 0;
                    if (lk_hit_i) begin m_idx = lk_idx_i; m_rd_due = cyc + 1; m_beat = 0; end
                    else begin m_done = 1; m_hit = 0; m_err = 0; end
                end
`ifdef GET_SEQ_TIMEOUT_EN
                else if (m_wait_cnt == TO - 1) begin
                    m_wait = 0; m_done = 1; m_hit = 0; m_err = 1;
                end else m_wait_cnt++;
`endif
            end
            if (m_req && lk_req_ready_i) begin
                m_req = 0; m_wait = 1; m_wait_cnt = 0;
                m_resp_at = (ks_lat == 0) ? -1 : cyc + ks_lat;
            end
            if (cyc == m_rd_due) m_val_from = cyc + 2;
            if (m_val && val_ready_i) begin
                m_val = 0; n_beat++;
                if (tput_on && last_acc >= 0) check_eq("throughput", cyc - last_acc, 3);
                last_acc = cyc;
                if (m_beat == VW - 1) begin m_done = 1; m_hit = 1; m_err = 0; end
                else begin m_beat++; m_rd_due = cyc + 1; end
            end
        end
        cyc++;
        if (cyc == m_val_from) m_val = 1;
    endtask

    task automatic run_get(input logic [31:0] k, input int abort_beat, input logic [31:0] akey);
        int  n = 0;
        bit  aborted = 0;
        step(1'b1, k);
        while (m_active && n < 3000) begin
            if (!aborted && abort_beat >= 0 && m_val && m_beat == abort_beat) begin
                step(1'b1, akey);
                aborted = 1;
                check_eq("abort_key", lk_key_o, akey);
                check_eq("abort_req", lk_req_valid_o, 1'b1);
            end else if ($urandom_range(999) < abort_pm) begin
                step(1'b1, $urandom);
            end else begin
                step(1'b0, 32'h0);
            end
            n++;
        end
        check_eq("get_complete", m_active, 1'b0);
    endtask

    task automatic do_reset();
        enter = 1'b1; en = 1'b1; key_i = $urandom; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; enter = 1'b0;
        model_clear();
        cyc++;
        #1;
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_req", lk_req_valid_o, 1'b0);
        check_eq("rst_key", lk_key_o, 32'h0);
        check_eq("rst_rd_en", rd_en_o, 1'b0);
        check_eq("rst_rd_idx", rd_idx_o, 4'h0);
        check_eq("rst_rd_word", rd_word_o, 2'h0);
        check_eq("rst_val_valid", val_valid_o, 1'b0);
        check_eq("rst_val_data", val_data_o, 32'h0);
        check_eq("rst_val_last", val_last_o, 1'b0);
        check_eq("rst_done", done_o, 1'b0);
        check_eq("rst_hit", hit_o, 1'b0);
        check_eq("rst_err", err_o, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; en = 0; enter = 0; key_i = 0; lk_req_ready_i = 0; lk_resp_valid_i = 0;
        lk_hit_i = 0; lk_idx_i = 0; rd_data_i = 0; val_ready_i = 0;
        ks_hit = 1; ks_idx = 5; ks_spur = 0; tput_on = 0; pulse_in_wait = 0;
        for (int e = 0; e < NE; e++)
            for (int w = 0; w < VW; w++) mem[e][w] = $urandom;
        for (int w = 0; w < VW; w++) mem[5][w] = 32'h10 + w;
        model_clear();
        do_reset();

        // Hit with continuous ready: 0x10..0x13, one word per 3 cycles.
        tput_on = 1; ks_hit = 1; ks_idx = 5; ks_lat = 2;
        run_get(32'hDEAD_BEEF, -1, 0);
        tput_on = 0;
        check_eq("hit_nrd", n_rd, 4);
        check_eq("hit_beats", n_beat, 4);
        check_eq("hit_done", seen_done, 1'b1);
        check_eq("hit_flag", seen_hit, 1'b1);

        // Miss: no reads, completion one cycle after the response.
        ks_hit = 0; ks_lat = 3;
        run_get(32'hCAFE_0001, -1, 0);
        check_eq("miss_nrd", n_rd, 0);
        check_eq("miss_done", seen_done, 1'b1);
        check_eq("miss_flag", seen_hit, 1'b0);

        // Backpressure on word 1 followed by a freeze.
        ks_hit = 1; ks_idx = 9; ks_lat = 1; bp_beat = 1; bp_left = 8;
        run_get(32'h0BAD_F00D, -1, 0);
        bp_beat = -1;
        check_eq("bp_nrd", n_rd, 4);
        check_eq("bp_beats", n_beat, 4);
        check_eq("bp_flag", seen_hit, 1'b1);

        // Restart while streaming word 2.
        ks_idx = 3;
        run_get(32'h5555_AAAA, 2, 32'h0000_1234);
        check_eq("abort_nrd", n_rd, 4);
        check_eq("abort_flag", seen_hit, 1'b1);

        // Reset in WAIT.
        ks_lat = 0;
        step(1'b1, 32'h7777_0000);
        for (int i = 0; i < 50 && !m_wait; i++) step(1'b0, 32'h0);
        check_eq("reached_wait", m_wait, 1'b1);
        do_reset();

        // Asynchronous glitch on rst_n between edges is ignored.
        ks_lat = 4; ks_idx = 12; pulse_in_wait = 1;
        run_get(32'h4242_4242, -1, 0);
        check_eq("glitch_flag", seen_hit, 1'b1);
        check_eq("glitch_nrd", n_rd, 4);

`ifdef GET_SEQ_TIMEOUT_EN
        ks_lat = 0;
        run_get(32'h7100_0001, -1, 0);
        check_eq("to_err", seen_err, 1'b1);
        check_eq("to_hit", seen_hit, 1'b0);
        ks_lat = TO; ks_hit = 1; ks_idx = 6;
        run_get(32'h7100_0002, -1, 0);
        check_eq("to_late_hit", seen_hit, 1'b1);
        check_eq("to_late_err", seen_err, 1'b0);
`endif

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            ks_hit   = ($urandom_range(99) < 70);
            ks_idx   = 4'($urandom);
`ifdef GET_SEQ_TIMEOUT_EN
            ks_lat   = $urandom_range(10, 1);
`else
            ks_lat   = $urandom_range(5, 1);
`endif
            ks_spur  = ($urandom_range(99) < 30);
            en_pct   = $urandom_range(100, 70);
            rdy_pct  = $urandom_range(100, 30);
            abort_pm = 20;
            run_get($urandom, -1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
